microwave_timer: RTL

MICROWAVE_TIMER -- requirements
Module: microwave_timer

---
 rtl/microwave_timer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/microwave_timer.sv
// Microwave cook timer: keypad entry of mm:ss in BCD, start/clear keys, 1 Hz countdown.
// Start/finish pulses go to the oven state machine. Countdown pauses while heat is low.
// Optional quick-start (+30 s key) is compiled in with `define MICROWAVE_QUICK_START_EN.
module microwave_timer (
  input  logic        clk,
  input  logic        nrst,
  input  logic        tick_i,
  input  logic        digit_valid_i,
  input  logic [3:0]  digit_i,
  input  logic        start_btn_i,
  input  logic        clear_btn_i,
  input  logic        door_i,
  input  logic        heat_i,
  output logic        start_o,
  output logic        finish_o,
  output logic [15:0] time_bcd_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {StIdle, StSet, StRun} state_e;

  state_e      state_q, state_d;
  logic [15:0] time_q, time_d;
  logic        start_q, start_d;
  logic        finish_q, finish_d;
  logic        busy_q, busy_d;
  logic [15:0] time_dec;

  // One-second BCD countdown; seconds above 59 are decremented as entered.
  always_comb begin
    time_dec = time_q;
    if (time_q[3:0] != 4'd0) begin
      time_dec[3:0] = time_q[3:0] - 4'd1;
    end else if (time_q[7:4] != 4'd0) begin
      time_dec[7:4] = time_q[7:4] - 4'd1;
      time_dec[3:0] = 4'd9;
    end else if (time_q[15:8] != 8'h00) begin
      time_dec[7:0] = 8'h59;
      if (time_q[11:8] != 4'd0) begin
        time_dec[11:8] = time_q[11:8] - 4'd1;
      end else begin
        time_dec[11:8]  = 4'd9;
        time_dec[15:12] = time_q[15:12] - 4'd1;
      end
    end
  end

`ifdef MICROWAVE_QUICK_START_EN
  logic [15:0] time_add;
  logic [3:0]  s1_sum;

  // Add 30 s in BCD, carrying into minutes and saturating at 99:59.
  always_comb begin
    time_add = time_q;
    s1_sum   = time_q[7:4] + 4'd3;
    if (s1_sum < 4'd6) begin
      time_add[7:4] = s1_sum;
    end else if (time_q[15:8] == 8'h99) begin
      time_add = 16'h9959;
    end else begin
      time_add[7:4] = s1_sum - 4'd6;
      if (time_q[11:8] == 4'd9) begin
        time_add[11:8]  = 4'd0;
        time_add[15:12] = time_q[15:12] + 4'd1;
      end else begin
        time_add[11:8] = time_q[11:8] + 4'd1;
      end
    end
  end
`endif

  // Next-state logic; clear has priority over every other key and the tick.
  always_comb begin
    state_d  = state_q;
    time_d   = time_q;
    start_d  = 1'b0;
    finish_d = 1'b0;
    if (clear_btn_i) begin
      state_d  = StIdle;
      time_d   = 16'h0000;
      finish_d = (state_q == StRun);
    end else begin
      unique case (state_q)
        StIdle, StSet: begin
          if (start_btn_i && !door_i && (state_q == StSet)) begin
            state_d = StRun;
            start_d = 1'b1;
          end
`ifdef MICROWAVE_QUICK_START_EN
          else if (start_btn_i && !door_i) begin
            state_d = StRun;
            time_d  = 16'h0030;
            start_d = 1'b1;
          end
`endif
          else if (digit_valid_i && (digit_i <= 4'd9) && (time_q[15:12] == 4'd0)) begin
            time_d  = {time_q[11:0], digit_i};
            state_d = ({time_q[11:0], digit_i} != 16'h0000) ? StSet : StIdle;
          end
        end
        StRun: begin
`ifdef MICROWAVE_QUICK_START_EN
          if (start_btn_i) begin
            time_d = time_add;
          end else
`endif
          if (tick_i && heat_i) begin
            time_d = time_dec;
            if (time_dec == 16'h0000) begin
              state_d  = StIdle;
              finish_d = 1'b1;
            end
          end
        end
        default: begin
          state_d = StIdle;
          time_d  = 16'h0000;
        end
      endcase
    end
    busy_d = (state_d == StRun);
  end

  // State and registered outputs; reset drops everything without a finish pulse.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= StIdle;
      time_q   <= 16'h0000;
      start_q  <= 1'b0;
      finish_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      time_q   <= time_d;
      start_q  <= start_d;
      finish_q <= finish_d;
      busy_q   <= busy_d;
    end
  end

  assign start_o    = start_q;
  assign finish_o   = finish_q;
  assign time_bcd_o = time_q;
  assign busy_o     = busy_q;

endmodule
